hit_resolver: RTL and testbench
===============================

# hit_resolver

Closest-hit resolver that sits directly downstream of the ray/triangle intersection stage. It accepts one ray, then consumes the stream of per-triangle intersection results for that ray, each formatted as {code[1:0], t}. It keeps the nearest valid hit and computes the intersection point start + t·dir with a single shared fixed-point multiplier. It then hands one resolved hit record to the reflection/refraction stage over a valid/ready handshake.

## Interface
- WIDTH, 32: fixed-point word width (two's complement).
- FRAC, 16: fractional bits of a fixed word.
- IDX_W, 8: triangle index width.
- clk in 1: single clock, all logic on rising edge.
- rst in 1: reset, synchronous and active-high.
- ray_valid in 1: ray offered.
- ray_ready out 1: resolver idle, ray may be accepted.
- ray_start in 3·WIDTH: {x,y,z} ray origin.
- ray_dir in 3·WIDTH: {x,y,z} ray direction.
- res_valid in 1: intersection result offered.
- res_ready out 1: result may be accepted.
- res_code in 2: 'b10 = hit, anything else = no hit.
- res_t in WIDTH: parametric distance, meaningful only when code = 'b10.
- res_idx in IDX_W: triangle index of this result.
- res_last in 1: final result for the current ray.
- hit_valid out 1: resolved record offered.
- hit_ready in 1: downstream accepts record.
- hit_found out 1: at least one hit was recorded.
- hit_idx out IDX_W: index of the nearest hit.
- hit_t out WIDTH: t of the nearest hit.
- hit_point out 3·WIDTH: {x,y,z} intersection point.
- hit_dir out 3·WIDTH: copy of the accepted ray_dir.

## Operation
- States: IDLE, COLLECT, MUL_X, MUL_Y, MUL_Z, OUT.
- **IDLE**
  - ray_ready = 1, res_ready = 0, hit_valid = 0.
  - On ray_valid: latch start and dir, clear found, go to COLLECT.
- **COLLECT**
  - res_ready = 1. One result is accepted per cycle when res_valid = 1.
  - A result with code = 'b10 replaces the stored best when found = 0 or when signed res_t < best_t. On replacement: best_t ← res_t, best_idx ← res_idx, found ← 1.
  - Ties (res_t == best_t) keep the earlier index.
  - Codes 'b00, 'b01 and 'b11 are ignored.
  - An accepted result with res_last = 1 is evaluated first. The state then goes to MUL_X if found (including a hit on the last beat itself); otherwise it goes to OUT.
- **MUL_X, MUL_Y, MUL_Z**
  - Each state computes one axis: point.a ← start.a + fMul(best_t, dir.a), where a is x, y, z in order.
- **OUT**
  - hit_valid = 1, and outputs stay stable until hit_ready.
  - On hit_valid & hit_ready, go to IDLE.
  - No-hit record: hit_found = 0, hit_t = 0, hit_idx = 0, hit_point = ray_start.
- **fMul**
  - Full 2·WIDTH-bit signed product, arithmetic shift right by FRAC (floor), low WIDTH bits kept.
  - The adds are WIDTH-bit two's complement and wrap on overflow; there is no saturation.
- hit_dir = latched ray_dir, unmodified.
- rst at any cycle, including mid-COLLECT or mid-OUT, forces IDLE at the next edge. Any partial ray is discarded with no record emitted.

## Timing
- Reset values:
  - ray_ready = 0 while rst = 1.
  - res_ready = 0, hit_valid = 0, hit_found = 0.
  - hit_idx, hit_t, hit_point and hit_dir are all 0.
- ray_ready = 1 on the first cycle after rst deasserts.
- Ray accepted at edge N → res_ready = 1 at N+1.
- Last result accepted at edge M:
  - hit found: MUL_X, MUL_Y, MUL_Z occupy M+1..M+3, and hit_valid = 1 at M+4.
  - no hit: hit_valid = 1 at M+1.
- Record accepted at edge K → ray_ready = 1 at K+1. The minimum gap between records is therefore one idle cycle.
- res_valid outside COLLECT is ignored (res_ready = 0). ray_valid outside IDLE is ignored (ray_ready = 0).
- Throughput in COLLECT is one result per cycle, and back-to-back beats carry no bubble.

## Test plan
- **Nearest hit.** Ray start (0,0,0), dir (0x00010000,0,0). Results:
  - idx0 code 10, t = 0x00018000
  - idx1 code 00
  - idx2 code 10, t = 0x00008000, last

  Required: hit_found = 1, idx = 2, t = 0x00008000, point = (0x00008000,0,0), hit_valid 4 cycles after the last beat.
- **No hit.** Start (0x00020000,0x00030000,0), results code 00 / 01 / 11 with last on the third beat. Required: hit_found = 0, point = start, t = 0, hit_valid 1 cycle after the last beat.
- **Tie and negative math.** Two hits with t = 0x00010000 at idx 5 then idx 7, dir (0xFFFF0000, 0x00008000, 0), start (0x00030000, 0, 0x00010000). Required: idx = 5, point = (0x00020000, 0x00008000, 0x00010000).
- **Backpressure.** hit_ready held low for 10 cycles. Required: all outputs stable, ray_ready = 0, a new ray_valid is ignored, and the next ray is accepted 1 cycle after the handshake.
- **Reset mid-COLLECT.** Assert rst after 2 of 4 results. Required: all outputs return to reset values, no record is emitted, and a fresh ray then resolves correctly.
- **Single hit on the last beat**, with res_valid gaps between beats. Required: a correct record, and the gaps do not alter best_t.

Source files
------------

// File: rtl/hit_resolver_if.sv
// Handshake bundle between the intersection stage, the closest-hit resolver
// and the reflection/refraction stage. The resolver is the slave side.
interface hit_resolver_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 8
);
    logic                   ray_valid;
    logic                   ray_ready;
    logic [3*WIDTH-1:0]     ray_start;
    logic [3*WIDTH-1:0]     ray_dir;

    logic                   res_valid;
    logic                   res_ready;
    logic [1:0]             res_code;
    logic [WIDTH-1:0]       res_t;
    logic [IDX_W-1:0]       res_idx;
    logic                   res_last;

    logic                   hit_valid;
    logic                   hit_ready;
    logic                   hit_found;
    logic [IDX_W-1:0]       hit_idx;
    logic [WIDTH-1:0]       hit_t;
    logic [3*WIDTH-1:0]     hit_point;
    logic [3*WIDTH-1:0]     hit_dir;

    modport master (
        output ray_valid, ray_start, ray_dir,
        output res_valid, res_code, res_t, res_idx, res_last,
        output hit_ready,
        input  ray_ready, res_ready,
        input  hit_valid, hit_found, hit_idx, hit_t, hit_point, hit_dir
    );

    modport slave (
        input  ray_valid, ray_start, ray_dir,
        input  res_valid, res_code, res_t, res_idx, res_last,
        input  hit_ready,
        output ray_ready, res_ready,
        output hit_valid, hit_found, hit_idx, hit_t, hit_point, hit_dir
    );
endinterface

// File: rtl/hit_resolver.sv
// Closest-hit resolver: accepts a ray, scans its intersection results for the
// nearest valid hit, then computes start + t*dir one axis at a time on a
// single shared fixed-point multiplier and offers one record downstream.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a ray (ray_ready high once out of reset)
// COLLECT | accepting results, tracking nearest hit
// MUL_X   | point.x <= start.x + t*dir.x
// MUL_Y   | point.y <= start.y + t*dir.y
// MUL_Z   | point.z <= start.z + t*dir.z
// OUT     | record offered, held stable until hit_ready
module hit_resolver #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int IDX_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    hit_resolver_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, COLLECT, MUL_X, MUL_Y, MUL_Z, OUT} state_t;

    state_t                   state;
    logic                     ray_ready_q;
    logic                     res_ready_q;
    logic                     hit_valid_q;
    logic                     found;
    logic signed [WIDTH-1:0]  best_t;
    logic [IDX_W-1:0]         best_idx;
    logic [3*WIDTH-1:0]       point;
    logic [3*WIDTH-1:0]       dir_q;

    logic signed [WIDTH-1:0]   mul_b;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0]   mul_q;
    logic                      res_hit;
    logic                      res_better;

    // Select the direction component for the axis being resolved.
    always_comb begin
        mul_b = dir_q[2*WIDTH +: WIDTH];
        case (state)
            MUL_Y:   mul_b = dir_q[WIDTH +: WIDTH];
            MUL_Z:   mul_b = dir_q[0 +: WIDTH];
            default: mul_b = dir_q[2*WIDTH +: WIDTH];
        endcase
    end

    // Shared multiplier; arithmetic shift floors, then wrap to WIDTH bits.
    assign prod  = best_t * mul_b;
    assign mul_q = WIDTH'(prod >>> FRAC);

    assign res_hit    = (bus.res_code == 2'b10);
    assign res_better = res_hit && (!found || ($signed(bus.res_t) < best_t));

    // Sequencer: all outputs registered. point is preloaded with the ray
    // origin, so each MUL state adds its product in place and a no-hit
    // record naturally reports the origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ray_ready_q <= 1'b0;
            res_ready_q <= 1'b0;
            hit_valid_q <= 1'b0;
            found       <= 1'b0;
            best_t      <= '0;
            best_idx    <= '0;
            point       <= '0;
            dir_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ray_ready_q <= 1'b1;
                    if (ray_ready_q && bus.ray_valid) begin
                        ray_ready_q <= 1'b0;
                        res_ready_q <= 1'b1;
                        point       <= bus.ray_start;
                        dir_q       <= bus.ray_dir;
                        found       <= 1'b0;
                        best_t      <= '0;
                        best_idx    <= '0;
                        state       <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.res_valid) begin
                        if (res_better) begin
                            best_t   <= $signed(bus.res_t);
                            best_idx <= bus.res_idx;
                            found    <= 1'b1;
                        end
                        if (bus.res_last) begin
                            res_ready_q <= 1'b0;
                            if (found || res_hit) begin
                                state <= MUL_X;
                            end else begin
                                hit_valid_q <= 1'b1;
                                state       <= OUT;
                            end
                        end
                    end
                end
                MUL_X: begin
                    point[2*WIDTH +: WIDTH] <= point[2*WIDTH +: WIDTH] + mul_q;
                    state <= MUL_Y;
                end
                MUL_Y: begin
                    point[WIDTH +: WIDTH] <= point[WIDTH +: WIDTH] + mul_q;
                    state <= MUL_Z;
                end
                MUL_Z: begin
                    point[0 +: WIDTH] <= point[0 +: WIDTH] + mul_q;
                    hit_valid_q <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (bus.hit_ready) begin
                        hit_valid_q <= 1'b0;
                        ray_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ray_ready = ray_ready_q;
    assign bus.res_ready = res_ready_q;
    assign bus.hit_valid = hit_valid_q;
    assign bus.hit_found = found;
    assign bus.hit_idx   = best_idx;
    assign bus.hit_t     = best_t;
    assign bus.hit_point = point;
    assign bus.hit_dir   = dir_q;

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: hand-computed records, latencies,
// backpressure stability and reset-mid-ray recovery.
module tb_hit_resolver;
    localparam int W  = 32;
    localparam int F  = 16;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hit_resolver_if #(.WIDTH(W), .IDX_W(IW)) bus ();

    hit_resolver #(.WIDTH(W), .FRAC(F), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".ray_ready"}, 96'(bus.ray_ready), 96'(0));
        chk({tag, ".res_ready"}, 96'(bus.res_ready), 96'(0));
        chk({tag, ".hit_valid"}, 96'(bus.hit_valid), 96'(0));
        chk({tag, ".hit_found"}, 96'(bus.hit_found), 96'(0));
        chk({tag, ".hit_idx"},   96'(bus.hit_idx),   96'(0));
        chk({tag, ".hit_t"},     96'(bus.hit_t),     96'(0));
        chk({tag, ".hit_point"}, bus.hit_point,      96'(0));
        chk({tag, ".hit_dir"},   bus.hit_dir,        96'(0));
    endtask

    task automatic send_ray(input string tag, input logic [95:0] s, input logic [95:0] d);
        chk({tag, ".ray_ready_pre"}, 96'(bus.ray_ready), 96'(1));
        bus.ray_valid = 1'b1;
        bus.ray_start = s;
        bus.ray_dir   = d;
        step();
        bus.ray_valid = 1'b0;
        chk({tag, ".res_ready_post"}, 96'(bus.res_ready), 96'(1));
    endtask

    task automatic beat(input logic [1:0] code, input logic [31:0] t,
                        input logic [7:0] idx, input logic last);
        bus.res_valid = 1'b1;
        bus.res_code  = code;
        bus.res_t     = t;
        bus.res_idx   = idx;
        bus.res_last  = last;
        step();
        bus.res_valid = 1'b0;
        bus.res_last  = 1'b0;
    endtask

    // Idle beat carrying tempting garbage that must not be consumed.
    task automatic gap();
        bus.res_valid = 1'b0;
        bus.res_code  = 2'b10;
        bus.res_t     = 32'h0000_0001;
        bus.res_idx   = 8'hEE;
        bus.res_last  = 1'b1;
        step();
        bus.res_last  = 1'b0;
    endtask

    task automatic wait_rec(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (bus.hit_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, ".latency"}, 96'(n), 96'(exp_lat));
    endtask

    task automatic check_rec(input string tag, input logic found, input logic [7:0] idx,
                             input logic [31:0] t, input logic [95:0] pt, input logic [95:0] d);
        chk({tag, ".hit_valid"}, 96'(bus.hit_valid), 96'(1));
        chk({tag, ".hit_found"}, 96'(bus.hit_found), 96'(found));
        chk({tag, ".hit_idx"},   96'(bus.hit_idx),   96'(idx));
        chk({tag, ".hit_t"},     96'(bus.hit_t),     96'(t));
        chk({tag, ".hit_point"}, bus.hit_point,      pt);
        chk({tag, ".hit_dir"},   bus.hit_dir,        d);
    endtask

    task automatic take_rec(input string tag);
        bus.hit_ready = 1'b1;
        step();
        bus.hit_ready = 1'b0;
        chk({tag, ".ray_ready_after"}, 96'(bus.ray_ready), 96'(1));
        chk({tag, ".hit_valid_after"}, 96'(bus.hit_valid), 96'(0));
    endtask

    initial begin
        bus.ray_valid = 1'b0;
        bus.ray_start = '0;
        bus.ray_dir   = '0;
        bus.res_valid = 1'b0;
        bus.res_code  = 2'b00;
        bus.res_t     = '0;
        bus.res_idx   = '0;
        bus.res_last  = 1'b0;
        bus.hit_ready = 1'b0;

        // Reset state
        repeat (3) step();
        check_reset_vals("reset");
        rst = 1'b0;
        step();
        chk("reset.ray_ready_first", 96'(bus.ray_ready), 96'(1));

        // Nearest hit
        send_ray("near", {32'h0, 32'h0, 32'h0}, {32'h0001_0000, 32'h0, 32'h0});
        beat(2'b10, 32'h0001_8000, 8'd0, 1'b0);
        beat(2'b00, 32'h0000_0001, 8'd1, 1'b0);
        beat(2'b10, 32'h0000_8000, 8'd2, 1'b1);
        wait_rec("near", 3);
        check_rec("near", 1'b1, 8'd2, 32'h0000_8000,
                  {32'h0000_8000, 32'h0, 32'h0}, {32'h0001_0000, 32'h0, 32'h0});
        take_rec("near");
        step();

        // No hit
        send_ray("nohit", {32'h0002_0000, 32'h0003_0000, 32'h0},
                 {32'h1111_1111, 32'h0000_2222, 32'h0000_0003});
        beat(2'b00, 32'h0000_0005, 8'd1, 1'b0);
        beat(2'b01, 32'h0000_0001, 8'd2, 1'b0);
        beat(2'b11, 32'h0000_0002, 8'd3, 1'b1);
        wait_rec("nohit", 0);
        check_rec("nohit", 1'b0, 8'd0, 32'h0, {32'h0002_0000, 32'h0003_0000, 32'h0},
                  {32'h1111_1111, 32'h0000_2222, 32'h0000_0003});
        take_rec("nohit");
        step();

        // Tie and negative math
        send_ray("tie", {32'h0003_0000, 32'h0, 32'h0001_0000},
                 {32'hFFFF_0000, 32'h0000_8000, 32'h0});
        beat(2'b10, 32'h0001_0000, 8'd5, 1'b0);
        beat(2'b10, 32'h0001_0000, 8'd7, 1'b1);
        wait_rec("tie", 3);
        check_rec("tie", 1'b1, 8'd5, 32'h0001_0000,
                  {32'h0002_0000, 32'h0000_8000, 32'h0001_0000},
                  {32'hFFFF_0000, 32'h0000_8000, 32'h0});
        take_rec("tie");
        step();

        // Backpressure: record held, competing ray ignored until handshake
        send_ray("bp", {32'h0, 32'h0, 32'h0}, {32'h0001_0000, 32'h0, 32'h0});
        beat(2'b10, 32'h0001_8000, 8'd0, 1'b0);
        beat(2'b00, 32'h0000_0001, 8'd1, 1'b0);
        beat(2'b10, 32'h0000_8000, 8'd2, 1'b1);
        wait_rec("bp", 3);
        bus.ray_valid = 1'b1;
        bus.ray_start = {32'h0005_0000, 32'h0006_0000, 32'h0007_0000};
        bus.ray_dir   = {32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp.hold_valid", 96'(bus.hit_valid), 96'(1));
            chk("bp.hold_idx", 96'(bus.hit_idx), 96'(2));
            chk("bp.hold_point", bus.hit_point, {32'h0000_8000, 32'h0, 32'h0});
            chk("bp.hold_dir", bus.hit_dir, {32'h0001_0000, 32'h0, 32'h0});
            chk("bp.ray_ready_low", 96'(bus.ray_ready), 96'(0));
        end
        bus.hit_ready = 1'b1;
        step();
        bus.hit_ready = 1'b0;
        chk("bp.ray_ready_k1", 96'(bus.ray_ready), 96'(1));
        chk("bp.res_ready_k1", 96'(bus.res_ready), 96'(0));
        step();
        bus.ray_valid = 1'b0;
        chk("bp.next_accepted", 96'(bus.res_ready), 96'(1));
        beat(2'b01, 32'h0, 8'd0, 1'b1);
        wait_rec("bp2", 0);
        check_rec("bp2", 1'b0, 8'd0, 32'h0,
                  {32'h0005_0000, 32'h0006_0000, 32'h0007_0000},
                  {32'h0000_0001, 32'h0000_0002, 32'h0000_0003});
        take_rec("bp2");
        step();

        // Reset mid-COLLECT, then a fresh ray with a negative nearest t
        send_ray("rst", {32'h0001_0000, 32'h0001_0000, 32'h0001_0000},
                 {32'h0001_0000, 32'h0001_0000, 32'h0001_0000});
        beat(2'b10, 32'h0003_0000, 8'd1, 1'b0);
        beat(2'b00, 32'h0000_0000, 8'd2, 1'b0);
        rst = 1'b1;
        step();
        check_reset_vals("rst_mid");
        rst = 1'b0;
        step();
        chk("rst_mid.ray_ready", 96'(bus.ray_ready), 96'(1));
        chk("rst_mid.no_record", 96'(bus.hit_valid), 96'(0));
        send_ray("fresh", {32'h0, 32'h0, 32'h0}, {32'h0001_0000, 32'h0002_0000, 32'h0});
        beat(2'b10, 32'h0002_0000, 8'd1, 1'b0);
        beat(2'b10, 32'hFFFF_8000, 8'd2, 1'b1);
        wait_rec("fresh", 3);
        check_rec("fresh", 1'b1, 8'd2, 32'hFFFF_8000,
                  {32'hFFFF_8000, 32'hFFFF_0000, 32'h0},
                  {32'h0001_0000, 32'h0002_0000, 32'h0});
        take_rec("fresh");
        step();

        // Single hit on last beat with gaps; z axis exercises floor of a negative product
        send_ray("last", {32'h0001_0000, 32'hFFFF_0000, 32'h0000_0100},
                 {32'h0002_0000, 32'h0000_4000, 32'hFFFF_FFFF});
        beat(2'b00, 32'h0000_0001, 8'd3, 1'b0);
        gap();
        beat(2'b01, 32'h0000_0001, 8'd4, 1'b0);
        gap();
        gap();
        beat(2'b10, 32'h0002_8000, 8'd9, 1'b1);
        wait_rec("last", 3);
        check_rec("last", 1'b1, 8'd9, 32'h0002_8000,
                  {32'h0006_0000, 32'hFFFF_A000, 32'h0000_00FD},
                  {32'h0002_0000, 32'h0000_4000, 32'hFFFF_FFFF});
        take_rec("last");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
